// File: rtl/hd_loader_if.sv
// Request, status, hard-drive and memory signals of the hd_loader transfer engine.
// The loader takes the master side; the BIOS/OS requester and the attached stores take the slave side.
interface hd_loader_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int TRACK_WIDTH    = 7,
  parameter int SECTOR_WIDTH   = 14,
  parameter int MEM_ADDR_WIDTH = 10
);
  logic                      start;
  logic                      direction;
  logic [TRACK_WIDTH-1:0]    track_in;
  logic [SECTOR_WIDTH-1:0]   sector_base;
  logic [MEM_ADDR_WIDTH-1:0] mem_base;
  logic [SECTOR_WIDTH-1:0]   word_count;
  logic [DATA_WIDTH-1:0]     hd_data_in;
  logic [TRACK_WIDTH-1:0]    hd_track;
  logic [SECTOR_WIDTH-1:0]   hd_sector;
  logic [DATA_WIDTH-1:0]     hd_data_out;
  logic                      flag_write_hd;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_data_out;
  logic [DATA_WIDTH-1:0]     mem_data_in;
  logic                      mem_write;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [DATA_WIDTH-1:0]     checksum;

  modport master (
    input  start, direction, track_in, sector_base, mem_base, word_count,
    input  hd_data_in, mem_data_in,
    output hd_track, hd_sector, hd_data_out, flag_write_hd,
    output mem_addr, mem_data_out, mem_write,
    output busy, done, error, checksum
  );

  modport slave (
    output start, direction, track_in, sector_base, mem_base, word_count,
    output hd_data_in, mem_data_in,
    input  hd_track, hd_sector, hd_data_out, flag_write_hd,
    input  mem_addr, mem_data_out, mem_write,
    input  busy, done, error, checksum
  );
endinterface

// File: rtl/hd_loader.sv
// Copies a run of sectors on one track to consecutive memory words (load) or back (store).
// Define HD_LOADER_CHECKSUM_EN to accumulate the modulo sum of every written word on checksum.
module hd_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int TRACK_WIDTH    = 7,
  parameter int SECTOR_WIDTH   = 14,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  hd_loader_if.master bus
);
  localparam int CW = ((SECTOR_WIDTH > MEM_ADDR_WIDTH) ? SECTOR_WIDTH : MEM_ADDR_WIDTH) + 2;
  localparam logic [CW-1:0] SECTOR_SPAN = CW'(1) << SECTOR_WIDTH;
  localparam logic [CW-1:0] MEM_SPAN    = CW'(1) << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CHECK, LD_RD, LD_WR, ST_RD, ST_WR, FIN} state_t;

  state_t                    state_q, state_d;
  logic                      direction_q, direction_d;
  logic [TRACK_WIDTH-1:0]    track_q, track_d;
  logic [SECTOR_WIDTH-1:0]   sector_base_q, sector_base_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_base_q, mem_base_d;
  logic [SECTOR_WIDTH-1:0]   word_count_q, word_count_d;
  logic [SECTOR_WIDTH-1:0]   idx_q, idx_d;
  logic [TRACK_WIDTH-1:0]    hd_track_q, hd_track_d;
  logic [SECTOR_WIDTH-1:0]   hd_sector_q, hd_sector_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
  logic                      mem_write_q, mem_write_d;
  logic                      flag_write_hd_q, flag_write_hd_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic [CW-1:0]             sector_end, mem_end;

  assign sector_end = CW'(sector_base_q) + CW'(word_count_q);
  assign mem_end    = CW'(mem_base_q) + CW'(word_count_q);

  always_comb begin
    state_d       = state_q;
    direction_d   = direction_q;
    track_d       = track_q;
    sector_base_d = sector_base_q;
    mem_base_d    = mem_base_q;
    word_count_d  = word_count_q;
    idx_d         = idx_q;
    hd_track_d    = hd_track_q;
    hd_sector_d   = hd_sector_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    error_d       = error_q;

    case (state_q)
      IDLE: if (bus.start) begin
        direction_d   = bus.direction;
        track_d       = bus.track_in;
        sector_base_d = bus.sector_base;
        mem_base_d    = bus.mem_base;
        word_count_d  = bus.word_count;
        idx_d         = '0;
        error_d       = 1'b0;
        state_d       = CHECK;
      end
      CHECK: begin
        if (sector_end > SECTOR_SPAN || mem_end > MEM_SPAN) begin
          error_d = 1'b1;
          state_d = FIN;
        end else if (word_count_q == '0) begin
          state_d = FIN;
        end else begin
          state_d = direction_q ? ST_RD : LD_RD;
        end
      end
      LD_RD: begin
        mem_data_d = bus.hd_data_in;
        state_d    = LD_WR;
      end
      LD_WR: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == word_count_q) ? FIN : LD_RD;
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == word_count_q) ? FIN : ST_RD;
      end
      default: state_d = IDLE;
    endcase

    // Addresses are loaded on entry to the state that uses them and then held, so
    // every strobe sees stable address and data for its whole cycle.
    if (state_d == LD_RD || state_d == ST_RD) begin
      hd_track_d  = track_q;
      hd_sector_d = sector_base_q + idx_d;
    end
    if (state_d == LD_WR || state_d == ST_RD) begin
      mem_addr_d = mem_base_q + MEM_ADDR_WIDTH'(idx_d);
    end

    mem_write_d     = (state_d == LD_WR);
    flag_write_hd_d = (state_d == ST_WR);
    busy_d          = (state_d != IDLE) && (state_d != FIN);
    done_d          = (state_d == FIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      direction_q     <= 1'b0;
      track_q         <= '0;
      sector_base_q   <= '0;
      mem_base_q      <= '0;
      word_count_q    <= '0;
      idx_q           <= '0;
      hd_track_q      <= '0;
      hd_sector_q     <= '0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      mem_write_q     <= 1'b0;
      flag_write_hd_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      direction_q     <= direction_d;
      track_q         <= track_d;
      sector_base_q   <= sector_base_d;
      mem_base_q      <= mem_base_d;
      word_count_q    <= word_count_d;
      idx_q           <= idx_d;
      hd_track_q      <= hd_track_d;
      hd_sector_q     <= hd_sector_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_write_q     <= mem_write_d;
      flag_write_hd_q <= flag_write_hd_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  assign bus.hd_track      = hd_track_q;
  assign bus.hd_sector     = hd_sector_q;
  assign bus.flag_write_hd = flag_write_hd_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_data_out  = mem_data_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  // Memory read data arrives during ST_WR, so it is forwarded straight onto the drive.
  assign bus.hd_data_out   = flag_write_hd_q ? bus.mem_data_in : '0;

`ifdef HD_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && bus.start) begin
      checksum_d = '0;
    end else if (mem_write_q) begin
      checksum_d = checksum_q + mem_data_q;
    end else if (flag_write_hd_q) begin
      checksum_d = checksum_q + bus.mem_data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_hd_loader.sv
// Bench for hd_loader: directed vector table, hand-written busy/reset sequences and random
// transfers, all checked against a copy-semantics model of the drive and memory contents.
module tb_hd_loader;
  localparam int DW      = 32;
  localparam int TW      = 7;
  localparam int SW      = 14;
  localparam int MW      = 10;
  localparam int SECTORS = 1 << SW;
  localparam int MWORDS  = 1 << MW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hd_loader_if #(.DATA_WIDTH(DW), .TRACK_WIDTH(TW), .SECTOR_WIDTH(SW), .MEM_ADDR_WIDTH(MW)) bus ();

  hd_loader #(.DATA_WIDTH(DW), .TRACK_WIDTH(TW), .SECTOR_WIDTH(SW), .MEM_ADDR_WIDTH(MW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic dir;
    int   tr;
    int   sb;
    int   mb;
    int   cnt;
    logic err;
    int   lat;
  } vec_t;

  vec_t          vt [10];
  logic [DW-1:0] mem [MWORDS];
  logic [DW-1:0] exp_mem [MWORDS];
  logic [DW-1:0] hd [int];
  logic [DW-1:0] exp_hd [int];
  int checks = 0, failures = 0;
  int n_mw = 0, n_hw = 0, n_both = 0;

  function automatic int hkey(int t, int s);
    return t * SECTORS + s;
  endfunction

  function automatic logic [DW-1:0] hd_rd(int t, int s);
    int k;
    k = hkey(t, s);
    return hd.exists(k) ? hd[k] : '0;
  endfunction

  // Reference: a request outside either address space is an error, and an error or an
  // empty request finishes two cycles after start; otherwise each word costs two cycles.
  function automatic void ref_outcome(int sb, int mb, int cnt, output logic err, output int lat);
    err = (sb + cnt > SECTORS) || (mb + cnt > MWORDS);
    lat = (err || cnt == 0) ? 2 : 2 + 2 * cnt;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: at the falling edge, commit any strobed write and refresh the read data.
  task automatic step();
    @(negedge clock);
    if (bus.mem_write) begin
      mem[bus.mem_addr] = bus.mem_data_out;
      n_mw++;
    end
    if (bus.flag_write_hd) begin
      hd[hkey(int'(bus.hd_track), int'(bus.hd_sector))] = bus.hd_data_out;
      n_hw++;
    end
    if (bus.mem_write && bus.flag_write_hd) n_both++;
    bus.mem_data_in = mem[bus.mem_addr];
    bus.hd_data_in  = hd_rd(int'(bus.hd_track), int'(bus.hd_sector));
  endtask

  task automatic do_xfer(string name, logic dir, int tr, int sb, int mb, int cnt, int inject,
                         logic exp_err, int exp_lat);
    logic [DW-1:0] exp_cs;
    logic [DW-1:0] w;
    logic          model_err;
    int            model_lat, lat, mm, base_mw, base_hw, base_both;
    ref_outcome(sb, mb, cnt, model_err, model_lat);
    foreach (mem[j]) exp_mem[j] = mem[j];
    exp_hd = hd;
    exp_cs = '0;
    if (!model_err) begin
      for (int j = 0; j < cnt; j++) begin
        if (!dir) begin
          w = hd_rd(tr, sb + j);
          exp_mem[mb + j] = w;
        end else begin
          w = mem[mb + j];
          exp_hd[hkey(tr, sb + j)] = w;
        end
        exp_cs += w;
      end
    end
    base_mw = n_mw; base_hw = n_hw; base_both = n_both;

    step();
    bus.direction   = dir;
    bus.track_in    = TW'(tr);
    bus.sector_base = SW'(sb);
    bus.mem_base    = MW'(mb);
    bus.word_count  = SW'(cnt);
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    chk({name, "/busy_after_start"}, bus.busy, 1);
    lat = 1;
    while (!bus.done && lat < exp_lat + 10) begin
      if (lat == inject) begin
        bus.start      = 1'b1;
        bus.direction  = ~dir;
        bus.mem_base   = MW'(mb + 64);
        bus.word_count = SW'(1);
      end
      step();
      bus.start = 1'b0;
      lat++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL %s/done_timeout: no done after %0d cycles, required at %0d", name, lat, exp_lat);
      return;
    end
    chk({name, "/latency"}, lat, exp_lat);
    chk({name, "/error"}, bus.error, exp_err);
    chk({name, "/busy_at_done"}, bus.busy, 0);
`ifdef HD_LOADER_CHECKSUM_EN
    chk({name, "/checksum"}, bus.checksum, exp_cs);
`else
    chk({name, "/checksum"}, bus.checksum, 0);
`endif
    step();
    chk({name, "/done_one_cycle"}, bus.done, 0);
    chk({name, "/mem_writes"}, n_mw - base_mw, (!dir && !model_err) ? cnt : 0);
    chk({name, "/hd_writes"}, n_hw - base_hw, (dir && !model_err) ? cnt : 0);
    chk({name, "/both_strobes"}, n_both - base_both, 0);
    mm = 0;
    foreach (mem[j]) if (mem[j] !== exp_mem[j]) mm++;
    chk({name, "/mem_image_diffs"}, mm, 0);
    mm = (hd.size() == exp_hd.size()) ? 0 : 1;
    foreach (exp_hd[k]) if (!hd.exists(k) || hd[k] !== exp_hd[k]) mm++;
    chk({name, "/hd_image_diffs"}, mm, 0);
    $display("xfer %s dir=%0d tr=%0d sb=%0d mb=%0d cnt=%0d lat=%0d err=%0d", name, dir, tr, sb, mb,
             cnt, lat, bus.error);
  endtask

  initial begin
    logic e;
    int   l, dir, tr, sb, mb, cnt, base, mm;

    reset = 1'b0;
    bus.start = 1'b0; bus.direction = 1'b0; bus.track_in = '0; bus.sector_base = '0;
    bus.mem_base = '0; bus.word_count = '0; bus.hd_data_in = '0; bus.mem_data_in = '0;
    foreach (mem[j]) mem[j] = $urandom;
    for (int j = 0; j < 4; j++) hd[hkey(0, j)] = DW'(j + 1);
    mem[5] = 32'hAAAA5555;
    mem[6] = 32'h12345678;

    step();
    step();
    chk("reset/busy", bus.busy, 0);
    chk("reset/done", bus.done, 0);
    chk("reset/error", bus.error, 0);
    chk("reset/checksum", bus.checksum, 0);
    chk("reset/strobes", {bus.mem_write, bus.flag_write_hd}, 0);
    chk("reset/addrs", {bus.mem_addr, bus.hd_track, bus.hd_sector}, 0);
    reset = 1'b1;

    vt[0] = '{1'b0, 0,   0,     16,   4,     1'b0, 10};
    vt[1] = '{1'b1, 3,   7,     5,    2,     1'b0, 6};
    vt[2] = '{1'b0, 1,   100,   50,   0,     1'b0, 2};
    vt[3] = '{1'b0, 0,   0,     1020, 8,     1'b1, 2};
    vt[4] = '{1'b0, 0,   0,     1020, 4,     1'b0, 10};
    vt[5] = '{1'b1, 127, 16380, 200,  4,     1'b0, 10};
    vt[6] = '{1'b1, 127, 16381, 200,  4,     1'b1, 2};
    vt[7] = '{1'b0, 5,   0,     1021, 4,     1'b1, 2};
    vt[8] = '{1'b1, 2,   16383, 1023, 1,     1'b0, 4};
    vt[9] = '{1'b0, 0,   1,     0,    16383, 1'b1, 2};
    for (int v = 0; v < 10; v++) begin
      do_xfer($sformatf("vec%0d", v), vt[v].dir, vt[v].tr, vt[v].sb, vt[v].mb, vt[v].cnt, 0,
              vt[v].err, vt[v].lat);
    end
    chk("vec0/mem19", mem[19], 4);
    chk("vec1/hd_3_8", hd_rd(3, 8), 32'h12345678);

    // A second start during a transfer must leave the running request untouched.
    for (int j = 0; j < 4; j++) hd[hkey(4, 20 + j)] = $urandom;
    do_xfer("busy_start_ld", 1'b0, 4, 20, 100, 4, 3, 1'b0, 10);
    do_xfer("busy_start_st", 1'b1, 4, 30, 400, 3, 4, 1'b0, 8);

    // Reset asserted while the third word of an eight-word load is being read.
    for (int j = 0; j < 8; j++) begin
      mem[300 + j] = 32'hDEAD0000 + DW'(j);
      hd[hkey(2, 50 + j)] = $urandom;
    end
    foreach (mem[j]) exp_mem[j] = mem[j];
    exp_mem[300] = hd_rd(2, 50);
    exp_mem[301] = hd_rd(2, 51);
    base = n_mw;
    step();
    bus.direction = 1'b0; bus.track_in = 7'd2; bus.sector_base = 14'd50;
    bus.mem_base = 10'd300; bus.word_count = 14'd8; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("abort/busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("abort/busy", bus.busy, 0);
    chk("abort/done_error", {bus.done, bus.error}, 0);
    chk("abort/strobes", {bus.mem_write, bus.flag_write_hd}, 0);
    chk("abort/addrs", {bus.mem_addr, bus.hd_track, bus.hd_sector}, 0);
    chk("abort/data", {bus.mem_data_out, bus.hd_data_out}, 0);
    chk("abort/checksum", bus.checksum, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort/mem_writes", n_mw - base, 2);
    mm = 0;
    foreach (mem[j]) if (mem[j] !== exp_mem[j]) mm++;
    chk("abort/mem_image_diffs", mm, 0);
    do_xfer("after_abort", 1'b0, 2, 52, 302, 2, 0, 1'b0, 6);

    for (int r = 0; r < 40; r++) begin
      dir = int'($urandom_range(0, 1));
      tr  = int'($urandom_range(0, 127));
      sb  = $urandom_range(0, 1) ? int'($urandom_range(16370, 16383)) : int'($urandom_range(0, 16383));
      mb  = $urandom_range(0, 1) ? int'($urandom_range(1014, 1023)) : int'($urandom_range(0, 1023));
      cnt = int'($urandom_range(0, 12));
      if (dir == 0) begin
        for (int j = 0; j < cnt; j++) if (sb + j < SECTORS) hd[hkey(tr, sb + j)] = $urandom;
      end
      ref_outcome(sb, mb, cnt, e, l);
      do_xfer($sformatf("rnd%0d", r), dir[0], tr, sb, mb, cnt, 0, e, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hd_loader.md
Name: hd_loader

Overview:
- Transfer engine between the hard drive block and the instruction/data memory.
- Drives the hard drive's track/sector/write-flag inputs and consumes its combinational read data.
- Copies a run of sectors on one track into consecutive memory words (load), or memory words back to sectors (store).
- Used by the BIOS/OS path to bring programs into memory before the processor fetches them.

Parameters:
DATA_WIDTH, 32, word width of hard drive and memory
TRACK_WIDTH, 7, hard drive track index width
SECTOR_WIDTH, 14, hard drive sector index width
MEM_ADDR_WIDTH, 10, memory word address width

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
direction  input  1  0 = HD->memory (load), 1 = memory->HD (store)
track_in  input  TRACK_WIDTH  track for the whole transfer
sector_base  input  SECTOR_WIDTH  first sector
mem_base  input  MEM_ADDR_WIDTH  first memory word
word_count  input  SECTOR_WIDTH  number of words
hd_data_in  input  DATA_WIDTH  hard drive read data (combinational on track/sector)
hd_track  output  TRACK_WIDTH  to hard drive track
hd_sector  output  SECTOR_WIDTH  to hard drive sector
hd_data_out  output  DATA_WIDTH  to hard drive data_write
flag_write_hd  output  1  hard drive write enable
mem_addr  output  MEM_ADDR_WIDTH  memory address
mem_data_out  output  DATA_WIDTH  memory write data
mem_data_in  input  DATA_WIDTH  memory read data, valid one cycle after mem_addr
mem_write  output  1  memory write enable
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of transfer
error  output  1  sticky range error; cleared by next accepted start
checksum  output  DATA_WIDTH  see Optional Feature

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0, including error and checksum. Internal counters 0.
- States: IDLE, CHECK, LD_RD, LD_WR, ST_RD, ST_WR, FIN.
- IDLE:
  - On start=1, latch all request inputs and clear error.
  - Next cycle CHECK; busy=1 from that cycle.
  - start while not IDLE is ignored, with no side effects.
- CHECK:
  - sector_base+word_count > 2^SECTOR_WIDTH, or mem_base+word_count > 2^MEM_ADDR_WIDTH, sets error=1 and goes to FIN with no writes. Sums are computed one bit wider.
  - word_count=0 goes to FIN with no writes, error=0.
  - Otherwise go to LD_RD (direction=0) or ST_RD (direction=1).
- Load, 2 cycles/word:
  - LD_RD drives hd_track/hd_sector and captures hd_data_in into a holding register at the cycle end.
  - LD_WR asserts mem_write=1 for exactly one cycle, with mem_addr=mem_base+i and mem_data_out=held word.
  - Then i++. If i==word_count go to FIN, else LD_RD.
- Store, 2 cycles/word:
  - ST_RD drives mem_addr=mem_base+i.
  - ST_WR asserts flag_write_hd=1 for one cycle, with hd_data_out=mem_data_in and hd_track/hd_sector = track_in/sector_base+i.
  - Then i++, with the same exit rule as load.
- Write-enable discipline:
  - mem_write and flag_write_hd are never both high.
  - Neither is high outside LD_WR/ST_WR.
  - Write data and address are held stable for the whole write cycle.
- FIN: done=1 for one cycle, busy=0, then IDLE. Transfer latency = 2 + 2*word_count cycles from start to done.
- Address registers hold their last values in IDLE.
- Reset mid-transfer aborts immediately. No further write strobes; a partial transfer is not rolled back.

Optional Feature:
- Macro HD_LOADER_CHECKSUM_EN.
- Defined:
  - checksum accumulates the modulo-2^DATA_WIDTH sum of every word written (load: held word; store: mem_data_in).
  - Cleared when a start is accepted; valid from the done pulse until the next accepted start.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Test Plan:
- Load: HD[0][0..3]=1,2,3,4; start, direction=0, track 0, sector_base 0, mem_base 16, count 4 -> mem[16..19]=1,2,3,4; done at cycle 10 after start; checksum=10 with the macro defined.
- Store: mem[5..6]=0xAAAA5555,0x12345678; direction=1, track 3, sector_base 7, count 2 -> HD[3][7..8] hold those values; exactly 2 flag_write_hd pulses.
- Zero count: count 0 -> done 2 cycles after start; no mem_write or flag_write_hd pulses; error=0.
- Range error: mem_base 1020, count 8 with MEM_ADDR_WIDTH 10 -> error=1, done pulse, no writes. Next valid start clears error.
- Start while busy: second start mid-load with different mem_base -> ignored; original transfer completes unchanged.
- Reset abort: reset low during the 3rd word of an 8-word load -> all outputs 0 immediately; only mem[base..base+1] written; after release, IDLE accepts a new start.
